regfile_mp: RTL and testbench

Parametrised multi-port integer register file, replacing the fixed 2R/1W 32x32 regfile in the decode stage. Provides NRD registered read ports that honour pipeline stall/flush, and NWR write ports for dual writeback with same-cycle write-to-read bypass. An optional sequential clear engine lets large or RAM-mapped arrays be zeroed one entry per cycle, after reset or on request, with a ready flag.

---
 rtl/regfile_mp.sv | 120 ++++++++++++
 tb/tb_regfile_mp.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with stall/flush-aware registered reads,
// same-cycle write-to-read bypass and an optional one-entry-per-cycle clear engine.
package regfile_mp_pkg;
    typedef struct packed {
        logic stall;
        logic flush;
    } PipeControl;
endpackage

module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter  int XLEN      = 32,
    parameter  int NREG      = 32,
    parameter  int NRD       = 2,
    parameter  int NWR       = 1,
    parameter  int ZERO_REG  = 1,
    parameter  int SEQ_CLEAR = 0,
    localparam int AW        = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  PipeControl           pipe,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 clear_req,
    output logic                 ready
);
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] rd_q  [NRD];
    logic [XLEN-1:0] rd_d  [NRD];
    logic [NWR-1:0]  wr_ok;
    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            clr_we;

    assign ready = state_q == READY;

    // A write that is dropped here is dropped for both the array and the bypass, so they agree.
    always_comb begin
        wr_ok = '0;
        for (int j = 0; j < NWR; j++)
            wr_ok[j] = wr_en[j] && ready && !(ZERO_REG != 0 && wr_addr[j*AW +: AW] == '0);
    end

    // Later assignments override earlier ones, giving flush > stall > not-ready > x0 > bypass > array.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_d[i] = mem_q[rd_addr[i*AW +: AW]];
            for (int j = 0; j < NWR; j++)
                if (wr_ok[j] && wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])
                    rd_d[i] = wr_data[j*XLEN +: XLEN];
            if (!ready || (ZERO_REG != 0 && rd_addr[i*AW +: AW] == '0))
                rd_d[i] = '0;
            if (pipe.stall)
                rd_d[i] = rd_q[i];
            if (pipe.flush)
                rd_d[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NRD; i++)
            rd_q[i] <= rst ? '0 : rd_d[i];
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        assign rd_data[i*XLEN +: XLEN] = rd_q[i];
    end

    // Exit is checked before the increment, so idx never wraps past NREG-1.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        clr_we  = 1'b0;
        if (SEQ_CLEAR == 0) begin
            state_d = READY;
        end else if (state_q == CLEAR) begin
            clr_we = 1'b1;
            if (idx_q == AW'(NREG - 1))
                state_d = READY;
            else
                idx_d = idx_q + AW'(1);
        end else if (clear_req) begin
            state_d = CLEAR;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Highest-index port is written last and wins; the clear write lands after all ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (SEQ_CLEAR == 0)
                for (int r = 0; r < NREG; r++)
                    mem_q[r] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++)
                if (wr_ok[j])
                    mem_q[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            if (clr_we)
                mem_q[idx_q] <= '0;
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vectors with a cycle-tagged expectation queue drained by a monitor.
module tb_regfile_mp;
  import regfile_mp_pkg::*;
  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   passed = 0;
  logic       rst_a, rst_c;
  PipeControl pipe_a, pipe_b, pipe_c;
  logic [9:0]  rda_a, rda_b, rda_c;
  logic [63:0] rdd_a, rdd_b, rdd_c;
  logic [1:0]  we_a;
  logic [9:0]  wa_a;
  logic [63:0] wd_a;
  logic [0:0]  we_b, we_c;
  logic [4:0]  wa_b, wa_c;
  logic [31:0] wd_b, wd_c;
  logic        clr_a, clr_b, clr_c, rdy_a, rdy_b, rdy_c;
  regfile_mp #(.NWR(2), .ZERO_REG(1), .SEQ_CLEAR(0)) ua (
    .clk(clk), .rst(rst_a), .pipe(pipe_a), .rd_addr(rda_a), .rd_data(rdd_a),
    .wr_en(we_a), .wr_addr(wa_a), .wr_data(wd_a), .clear_req(clr_a), .ready(rdy_a));
  regfile_mp #(.NWR(1), .ZERO_REG(0), .SEQ_CLEAR(0)) ub (
    .clk(clk), .rst(rst_a), .pipe(pipe_b), .rd_addr(rda_b), .rd_data(rdd_b),
    .wr_en(we_b), .wr_addr(wa_b), .wr_data(wd_b), .clear_req(clr_b), .ready(rdy_b));
  regfile_mp #(.NWR(1), .ZERO_REG(1), .SEQ_CLEAR(1)) uc (
    .clk(clk), .rst(rst_c), .pipe(pipe_c), .rd_addr(rda_c), .rd_data(rdd_c),
    .wr_en(we_c), .wr_addr(wa_c), .wr_data(wd_c), .clear_req(clr_c), .ready(rdy_c));
  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0:       return rdd_a[31:0];
      1:       return rdd_a[63:32];
      2:       return {31'b0, rdy_a};
      3:       return rdd_b[31:0];
      4:       return rdd_c[31:0];
      default: return {31'b0, rdy_c};
    endcase
  endfunction
  task automatic chk(input int sel, input logic [31:0] exp, input string name);
    q.push_back('{cyc + 1, sel, exp, name});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      total++;
      if (e.cyc == cyc && obs(e.sel) === e.exp)
        passed++;
      else
        $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)", e.name, obs(e.sel), e.exp, cyc, e.cyc);
    end
  end
  initial begin
    rst_a = 1; rst_c = 1;
    pipe_a = '0; pipe_b = '0; pipe_c = '0;
    rda_a = '0; rda_b = '0; rda_c = '0;
    we_a = '0; wa_a = '0; wd_a = '0;
    we_b = '0; wa_b = '0; wd_b = '0;
    we_c = '0; wa_c = '0; wd_c = '0;
    clr_a = 0; clr_b = 0; clr_c = 0;
    step();
    rda_a = {5'd7, 5'd5};
    chk(0, 0, "rst_rd0"); chk(1, 0, "rst_rd1"); chk(2, 0, "rst_ready");
    step();
    rst_a = 0;
    chk(2, 1, "ready_after_rst");
    step();
    chk(0, 0, "cleared_x5"); chk(1, 0, "cleared_x7");
    step();
    we_a = 2'b11; wa_a = {5'd3, 5'd3}; wd_a = {32'h5555FFFF, 32'hAAAA0000}; rda_a = {5'd7, 5'd3};
    chk(0, 32'h5555FFFF, "conflict_bypass");
    step();
    we_a = 2'b00; rda_a = {5'd3, 5'd3};
    chk(0, 32'h5555FFFF, "conflict_array0"); chk(1, 32'h5555FFFF, "conflict_array1");
    step();
    we_a = 2'b01; wa_a = {5'd0, 5'd6}; wd_a = {32'h0, 32'h11112222}; rda_a = {5'd6, 5'd3};
    chk(0, 32'h5555FFFF, "read_x3"); chk(1, 32'h11112222, "bypass_port0");
    step();
    we_a = 2'b11; wa_a = {5'd8, 5'd6}; wd_a = {32'hCAFEF00D, 32'h33334444}; rda_a = {5'd8, 5'd6};
    chk(0, 32'h33334444, "bypass_dual0"); chk(1, 32'hCAFEF00D, "bypass_dual1");
    step();
    we_a = 2'b01; wa_a = '0; wd_a = {32'h0, 32'hDEADBEEF}; rda_a = {5'd6, 5'd0};
    we_b = 1'b1; wa_b = 5'd0; wd_b = 32'hDEADBEEF; rda_b = '0;
    chk(0, 0, "x0_zero_bypass"); chk(1, 32'h33334444, "read_x6"); chk(3, 32'hDEADBEEF, "x0_plain_bypass");
    step();
    we_a = 2'b00; we_b = 1'b0;
    chk(0, 0, "x0_zero_array"); chk(3, 32'hDEADBEEF, "x0_plain_array");
    step();
    we_a = 2'b01; wa_a = {5'd0, 5'd4}; wd_a = {32'h0, 32'h12345678}; rda_a = {5'd6, 5'd4};
    chk(0, 32'h12345678, "x4_bypass");
    step();
    we_a = 2'b10; wa_a = {5'd9, 5'd0}; wd_a = {32'h99990009, 32'h0};
    chk(0, 32'h12345678, "x4_array"); chk(1, 32'h33334444, "x6_pre_stall");
    step();
    pipe_a.stall = 1; we_a = 2'b01; wa_a = {5'd0, 5'd10}; wd_a = {32'h0, 32'hA0A0A0A0}; rda_a = {5'd9, 5'd9};
    chk(0, 32'h12345678, "stall_hold0"); chk(1, 32'h33334444, "stall_hold1");
    step();
    we_a = 2'b00; pipe_a.flush = 1;
    chk(0, 0, "stall_flush0"); chk(1, 0, "stall_flush1");
    step();
    pipe_a = '0; rda_a = {5'd10, 5'd9};
    chk(0, 32'h99990009, "after_stall_x9"); chk(1, 32'hA0A0A0A0, "write_during_stall");
    step();
    rst_c = 0;
    for (int k = 0; k < 32; k++) begin
      chk(5, {31'b0, k == 31}, "init_clear_ready");
      step();
    end
    for (int r = 1; r < 32; r++) begin
      we_c = 1'b1; wa_c = 5'(r); wd_c = 32'h1000 + r; rda_c = {5'd0, 5'(r)};
      chk(4, 32'h1000 + r, "fill_bypass");
      step();
    end
    we_c = 1'b0; rda_c = {5'd0, 5'd5};
    chk(4, 32'h1005, "fill_x5");
    step();
    for (int k = 0; k <= 32; k++) begin
      clr_c = k == 0;
      we_c = k < 30;
      wa_c = (k == 0) ? 5'd7 : 5'd5;
      wd_c = (k == 0) ? 32'h7777 : 32'hBAD00BAD;
      rda_c = {5'd0, wa_c};
      chk(5, {31'b0, k == 32}, "clear_ready");
      if (k == 0) chk(4, 32'h7777, "clear_cycle_bypass");
      if (k == 10) chk(4, 0, "read_in_clear");
      step();
    end
    we_c = 1'b0; clr_c = 0; rda_c = {5'd0, 5'd5};
    chk(4, 0, "lost_write_x5");
    step();
    rda_c = {5'd0, 5'd7};
    chk(4, 0, "cleared_x7");
    step();
    rda_c = {5'd0, 5'd31};
    chk(4, 0, "cleared_x31");
    step();
    we_c = 1'b1; wa_c = 5'd31; wd_c = 32'h31313131;
    chk(4, 32'h31313131, "x31_bypass");
    step();
    we_c = 1'b0; clr_c = 1;
    chk(5, 0, "mid_clear_start");
    step();
    clr_c = 0;
    repeat (10) step();
    rst_c = 1;
    chk(5, 0, "mid_clear_rst");
    step();
    rst_c = 0;
    for (int k = 0; k < 32; k++) begin
      clr_c = k == 20;
      chk(5, {31'b0, k == 31}, "restart_ready");
      step();
    end
    clr_c = 0; rda_c = {5'd0, 5'd31};
    chk(4, 0, "x31_after_restart");
    step();
    total++;
    if (rdy_c === 1'b1) passed++;
    else $display("FAIL ready_c_final: got %b expected 1", rdy_c);
    total++;
    if (rdy_a === 1'b1) passed++;
    else $display("FAIL ready_a_final: got %b expected 1", rdy_a);
    for (int w = 0; w < 4 && q.size() > 0; w++) @(negedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      total++;
      $display("FAIL %s: never checked, expected %h", e.name, e.exp);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
